// File: rtl/ifftout_axis.sv
// Inverse-FFT output adapter: convergent rounding of each component to OW bits,
// bin-0/last-bin tagging, and a FWFT FIFO presented as a valid/ready stream.
module ifftout_axis #(
  parameter int IW     = 21,
  parameter int OW     = 16,
  parameter int LGFFT  = 11,
  parameter int LGFIFO = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic [2*IW-1:0]   i_result,
  input  logic              i_sync,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2*OW-1:0]   o_data,
  output logic              o_first,
  output logic              o_last,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_overflow,
  output logic              o_sync_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DROP} state_t;

  localparam int                DEPTH     = 1 << LGFIFO;
  localparam int                EW        = 2*OW + 2;
  localparam logic [LGFFT-1:0]  LAST_BIN  = '1;
  localparam logic [LGFIFO:0]   FULL_FILL = (LGFIFO+1)'(DEPTH);

  state_t            r_state, w_next_state;
  logic [LGFFT-1:0]  r_cnt, w_bin;
  logic              w_accept, w_sync_err, w_last;
  logic              r_in_valid, r_in_first, r_in_last;
  logic [2*IW-1:0]   r_in_data;
  logic              r_rnd_valid;
  logic [EW-1:0]     r_rnd_entry;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [LGFIFO-1:0] r_wr_ptr, r_rd_ptr;
  logic [LGFIFO:0]   r_fill;
  logic              r_overflow, r_sync_err;
  logic              w_full, w_push, w_ovf_hit, w_pop;
  logic [EW-1:0]     w_head;

  // Round half to even on the dropped bits; only a positive input can carry into the sign.
  function automatic logic [OW-1:0] round_conv(input logic [IW-1:0] x);
    logic [IW-1:0] w_sum;
    w_sum = x + IW'((1 << (IW-OW-1)) - 1) + {{(IW-1){1'b0}}, x[IW-OW]};
    if (!x[IW-1] && w_sum[IW-1]) round_conv = {1'b0, {(OW-1){1'b1}}};
    else                         round_conv = w_sum[IW-1:IW-OW];
  endfunction

  assign w_full    = (r_fill == FULL_FILL);
  assign w_push    = r_rnd_valid && !w_full;
  assign w_ovf_hit = r_rnd_valid && w_full;
  assign o_valid   = (r_fill != '0);
  assign w_pop     = o_valid && i_ready;
  assign w_bin     = i_sync ? '0 : r_cnt;
  assign w_last    = (w_bin == LAST_BIN);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_sync_err   = 1'b0;
    if (w_ovf_hit) begin
      w_next_state = S_DROP;
    end else if (i_ce) begin
      case (r_state)
        S_IDLE: if (i_sync) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
        S_RUN: begin
          w_accept   = 1'b1;
          w_sync_err = i_sync && (r_cnt != '0);
        end
        S_DROP: if (i_sync && !w_full) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignment so every register sees pre-edge values.
  // A dropped push also flushes the in-flight samples so the partial frame ends cleanly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_valid  <= 1'b0;
      r_rnd_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_sync_err  <= w_sync_err;
      r_in_valid  <= w_accept;
      r_rnd_valid <= r_in_valid && !w_ovf_hit;
      if (w_accept)  r_cnt      <= w_bin + LGFFT'(1);
      if (w_ovf_hit) r_overflow <= 1'b1;
    end
  end

  // NOTE: datapath registers and FIFO storage carry no reset; the valid bits and
  // pointers are what make their contents meaningful.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_in_data  <= i_result;
      r_in_first <= i_sync;
      r_in_last  <= w_last;
    end
    r_rnd_entry <= {r_in_first, r_in_last,
                    round_conv(r_in_data[2*IW-1:IW]), round_conv(r_in_data[IW-1:0])};
    if (w_push) r_mem[r_wr_ptr] <= r_rnd_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LGFIFO'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LGFIFO'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (LGFIFO+1)'(1);
        2'b01:   r_fill <= r_fill - (LGFIFO+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Head entry is gated so the stream outputs read zero whenever the FIFO is empty.
  assign w_head = r_mem[r_rd_ptr];
  assign {o_first, o_last, o_data} = o_valid ? w_head : '0;
  assign o_fill     = r_fill;
  assign o_overflow = r_overflow;
  assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_ifftout_axis.sv
// Scoreboard bench for ifftout_axis: stimulus pushes expected samples, a negedge
// monitor pops and compares on every accepted output.
module tb_ifftout_axis;
  localparam int IW = 21, OW = 16, LGFFT = 11, LGFIFO = 5;
  localparam int NBIN = 1 << LGFFT;

  localparam int R_IN  [7] = '{16, 48, 80, -16, -48, 'h0FFFFF, 'h100000};
  localparam int R_EXP [7] = '{0, 2, 2, 0, -2, 'h7FFF, 'h8000};
  localparam int I_IN  [7] = '{32, 96, 'h0FFFF0, 'h0FFFD0, -32, 112, 0};
  localparam int I_EXP [7] = '{1, 3, 'h7FFF, 'h7FFE, -1, 4, 0};

  logic            clk = 1'b0;
  logic            rst = 1'b1, ce = 1'b0, sync = 1'b0, rdy = 1'b1;
  logic [2*IW-1:0] res = '0;
  logic            o_valid, o_first, o_last, o_overflow, o_sync_err;
  logic [2*OW-1:0] o_data;
  logic [LGFIFO:0] o_fill;

  logic [2*OW+1:0] q[$];
  int n_tests = 0, n_fail = 0, n_out = 0;

  ifftout_axis #(.IW(IW), .OW(OW), .LGFFT(LGFFT), .LGFIFO(LGFIFO)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_result(res), .i_sync(sync),
    .o_valid(o_valid), .i_ready(rdy), .o_data(o_data), .o_first(o_first),
    .o_last(o_last), .o_fill(o_fill), .o_overflow(o_overflow), .o_sync_err(o_sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*IW-1:0] mk(input int re, input int im);
    return {re[IW-1:0], im[IW-1:0]};
  endfunction

  task automatic expect_s(input logic first, input logic last, input int re, input int im);
    q.push_back({first, last, re[OW-1:0], im[OW-1:0]});
  endtask

  task automatic drive(input logic c, input logic s, input logic [2*IW-1:0] r);
    ce = c; sync = s; res = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; sync = 1'b0; res = '0;
    @(posedge clk); #1;
    check("rst_valid", o_valid, 0);
    check("rst_fill", o_fill, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_sync_err", o_sync_err, 0);
    check("rst_stream", {o_first, o_last, o_data}, 0);
    rst = 1'b0;
    n_out = 0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    ce = 1'b0; sync = 1'b0; rdy = 1'b1;
    while ((q.size() != 0 || o_valid) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_drained"}, q.size(), 0);
    q.delete();
  endtask

  initial begin : monitor
    logic [2*OW+1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && o_valid && rdy) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected none", {o_first, o_last, o_data});
        end else begin
          e = q.pop_front();
          check($sformatf("out%0d", n_out), {o_first, o_last, o_data}, e);
        end
        n_out++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bb;
    rdy = 1'b1;

    // Nominal frame with latency check
    do_reset();
    for (int b = 0; b < NBIN; b++) begin
      expect_s(b == 0, b == NBIN-1, b, -b);
      drive(1'b1, b == 0, mk(b << 5, -(b << 5)));
      if (b < 2)  check("t1_latency_low", o_valid, 0);
      if (b == 2) check("t1_latency_high", o_valid, 1);
    end
    drain("t1");
    check("t1_overflow", o_overflow, 0);
    check("t1_count", n_out, NBIN);

    // Rounding and saturation vectors
    do_reset();
    for (int i = 0; i < 7; i++) begin
      expect_s(i == 0, 1'b0, R_EXP[i], I_EXP[i]);
      drive(1'b1, i == 0, mk(R_IN[i], I_IN[i]));
    end
    drain("t2");

    // Backpressure: overflow, drop to next sync, resume
    do_reset();
    rdy = 1'b0;
    for (int b = 0; b < NBIN; b++) begin
      if (b < 32) expect_s(b == 0, 1'b0, b, -b);
      if (b == 200) rdy = 1'b1;
      drive(1'b1, b == 0, mk(b << 5, -(b << 5)));
      if (b == 32) check("t3_fill_31", o_fill, 31);
      if (b == 33) begin
        check("t3_fill_32", o_fill, 32);
        check("t3_no_ovf_yet", o_overflow, 0);
      end
      if (b == 34) check("t3_overflow", o_overflow, 1);
      if (b == 100) begin
        check("t3_fill_held", o_fill, 32);
        check("t3_head_stable", {o_first, o_last, o_data}, 34'h2_0000_0000);
      end
      if (b == 250) begin
        check("t3_fill_empty", o_fill, 0);
        check("t3_sticky", o_overflow, 1);
      end
    end
    for (int b = 0; b < NBIN; b++) begin
      expect_s(b == 0, b == NBIN-1, b, -b);
      drive(1'b1, b == 0, mk(b << 5, -(b << 5)));
    end
    drain("t3");
    check("t3_sticky_end", o_overflow, 1);
    check("t3_count", n_out, 32 + NBIN);

    // Pre-sync samples dropped; CE gating with sync asserted on idle cycles
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, mk((1000 + i) << 5, 7 << 5));
    for (int b = 0; b < NBIN; b++) begin
      expect_s(b == 0, b == NBIN-1, b, b ^ 'h55);
      drive(1'b1, b == 0, mk(b << 5, (b ^ 'h55) << 5));
      drive(1'b0, 1'b1, mk('h0ABCDE, 'h012345));
    end
    drain("t4");
    check("t4_count", n_out, NBIN);

    // Misplaced sync at bin 100, then a correct sync at the wrapped bin 0
    do_reset();
    for (int i = 0; i < 100 + NBIN; i++) begin
      bb = (i < 100) ? i : i - 100;
      expect_s(i == 0 || i == 100, i >= 100 && bb == NBIN-1, i, 0);
      drive(1'b1, i == 0 || i == 100, mk(i << 5, 0));
      if (i == 99 || i == 101) check("t5_sync_err_low", o_sync_err, 0);
      if (i == 100) check("t5_sync_err_pulse", o_sync_err, 1);
    end
    expect_s(1'b1, 1'b0, 'h1234, 0);
    drive(1'b1, 1'b1, mk('h1234 << 5, 0));
    check("t5_sync_ok", o_sync_err, 0);
    drain("t5");
    check("t5_count", n_out, 101 + NBIN);

    // Reset mid-frame with 20 entries buffered
    do_reset();
    for (int b = 0; b < 500; b++) begin
      if (b <= 477) expect_s(b == 0, 1'b0, b, -b);
      if (b == 481) rdy = 1'b0;
      drive(1'b1, b == 0, mk(b << 5, -(b << 5)));
    end
    check("t6_fill_before", o_fill, 20);
    check("t6_popped", n_out, 478);
    check("t6_queue", q.size(), 0);
    rst = 1'b1;
    drive(1'b1, 1'b0, mk(500 << 5, -(500 << 5)));
    check("t6_valid_after", o_valid, 0);
    check("t6_fill_after", o_fill, 0);
    check("t6_ovf_after", o_overflow, 0);
    rst = 1'b0;
    rdy = 1'b1;
    for (int b = 501; b < 531; b++) drive(1'b1, 1'b0, mk(b << 5, -(b << 5)));
    check("t6_dropped", o_fill, 0);
    for (int b = 0; b < 5; b++) begin
      expect_s(b == 0, 1'b0, b + 10, -b);
      drive(1'b1, b == 0, mk((b + 10) << 5, -(b << 5)));
    end
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
